// File: rtl/sme_host_driver_pkg.sv
// ---------------------------------------------------------------------------
// sme_host_driver_pkg
// Shared definitions for the string-matching-engine host driver:
//   - state_t          : controller state encoding
//   - *_MAX_DEFAULT    : default buffer depths and result timeout
//   - CH_*             : pattern metacharacters understood by the matcher
//   - idxWidth()       : index width for a buffer of a given depth
// ---------------------------------------------------------------------------
package sme_host_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_GAP      = 3'd2,
        ST_SEND_PAT = 3'd3,
        ST_WAIT     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int STR_MAX_DEFAULT  = 32;
    localparam int PAT_MAX_DEFAULT  = 8;
    localparam int WAIT_MAX_DEFAULT = 64;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    // A depth-1 buffer still needs a one-bit index so port widths stay legal.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sme_char_buf.sv
// ---------------------------------------------------------------------------
// sme_char_buf
// Append-only character buffer of DEPTH bytes with a saturating length.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset (empties buffer)
//   i_wr, i_wdata    append one byte; dropped when the buffer is full
//   i_clr            empty the buffer; wins over a simultaneous i_wr
//   i_rd_idx         combinational read index
//   o_rdata          byte at i_rd_idx
//   o_len            number of bytes held (0..DEPTH)
// ---------------------------------------------------------------------------
module sme_char_buf
    import sme_host_driver_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int IDX_W = idxWidth(DEPTH),
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr,
    input  logic [7:0]       i_wdata,
    input  logic             i_clr,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rdata,
    output logic [LEN_W-1:0] o_len
);

    logic [7:0]       r_mem [DEPTH];
    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_wrPtr;
    logic             w_full;
    logic             w_accept;

    assign w_full   = (r_len == LEN_W'(DEPTH));
    assign w_accept = i_wr && !i_clr && !w_full;

    // Length and write pointer advance together; clear has priority.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_len   <= '0;
            r_wrPtr <= '0;
        end else if (i_clr) begin
            r_len   <= '0;
            r_wrPtr <= '0;
        end else if (w_accept) begin
            r_len   <= r_len + LEN_W'(1);
            r_wrPtr <= (r_wrPtr == IDX_W'(DEPTH - 1)) ? '0 : r_wrPtr + IDX_W'(1);
        end
    end

    // Storage carries no reset; only bytes below r_len are ever read.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_rd_idx];
    assign o_len   = r_len;

endmodule

// File: rtl/sme_host_driver.sv
// ---------------------------------------------------------------------------
// sme_host_driver
// Host-side driver for a string matching engine. Holds a string and a
// pattern buffer, streams them to the matcher with isstring/ispattern
// qualifiers, then waits (bounded) for the matcher's result strobe.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_str_wr/i_str_wdata/i_str_clr string buffer append / clear
//   i_pat_wr/i_pat_wdata/i_pat_clr pattern buffer append / clear
//   i_start_full                   send string, one gap cycle, then pattern
//   i_start_pat                    send pattern only (string already sent)
//   o_chardata, o_isstring,
//   o_ispattern                    character stream to the matcher
//   i_valid, i_match,
//   i_match_index                  matcher result, qualified by i_valid
//   o_busy                         high whenever not idle
//   o_done                         one-cycle completion pulse
//   o_res_match, o_res_index,
//   o_err                          result of the last run, held until next done
// ---------------------------------------------------------------------------
module sme_host_driver
    import sme_host_driver_pkg::*;
#(
    parameter int STR_MAX  = STR_MAX_DEFAULT,
    parameter int PAT_MAX  = PAT_MAX_DEFAULT,
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_str_wr,
    input  logic [7:0] i_str_wdata,
    input  logic       i_str_clr,
    input  logic       i_pat_wr,
    input  logic [7:0] i_pat_wdata,
    input  logic       i_pat_clr,
    input  logic       i_start_full,
    input  logic       i_start_pat,
    output logic [7:0] o_chardata,
    output logic       o_isstring,
    output logic       o_ispattern,
    input  logic       i_valid,
    input  logic       i_match,
    input  logic [4:0] i_match_index,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_res_match,
    output logic [4:0] o_res_index,
    output logic       o_err
);

    localparam int SIDX_W  = idxWidth(STR_MAX);
    localparam int PIDX_W  = idxWidth(PAT_MAX);
    localparam int SLEN_W  = $clog2(STR_MAX + 1);
    localparam int PLEN_W  = $clog2(PAT_MAX + 1);
    localparam int CNT_W   = $clog2(((STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX) + 1);
    localparam int WCNT_W  = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  w_idxNext;
    logic [WCNT_W-1:0] r_waitCnt;
    logic              r_strSent;
    logic              r_resMatch;
    logic [4:0]        r_resIndex;
    logic              r_err;

    logic              w_idle;
    logic              w_bufWrEn;
    logic [7:0]        w_strData;
    logic [7:0]        w_patData;
    logic [SLEN_W-1:0] w_strLen;
    logic [PLEN_W-1:0] w_patLen;
    logic              w_strLast;
    logic              w_patLast;
    logic              w_startFullErr;
    logic              w_startPatErr;
    logic              w_waitExpired;

    // Buffer writes are blocked in the cycle a start is accepted so the
    // length being streamed cannot change underneath the send.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_bufWrEn = w_idle && !i_start_full && !i_start_pat;

    sme_char_buf #(.DEPTH(STR_MAX)) u_strBuf (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (w_bufWrEn && i_str_wr),
        .i_wdata  (i_str_wdata),
        .i_clr    (w_bufWrEn && i_str_clr),
        .i_rd_idx (r_idx[SIDX_W-1:0]),
        .o_rdata  (w_strData),
        .o_len    (w_strLen)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_patBuf (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (w_bufWrEn && i_pat_wr),
        .i_wdata  (i_pat_wdata),
        .i_clr    (w_bufWrEn && i_pat_clr),
        .i_rd_idx (r_idx[PIDX_W-1:0]),
        .o_rdata  (w_patData),
        .o_len    (w_patLen)
    );

    assign w_idxNext      = r_idx + CNT_W'(1);
    assign w_strLast      = (w_idxNext == CNT_W'(w_strLen));
    assign w_patLast      = (w_idxNext == CNT_W'(w_patLen));
    assign w_startFullErr = (w_strLen == '0) || (w_patLen == '0);
    assign w_startPatErr  = (w_patLen == '0) || !r_strSent;
    assign w_waitExpired  = (r_waitCnt == WCNT_W'(WAIT_MAX - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Invalid starts go straight to DONE so the host
    // still gets a done pulse carrying err.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start_full) begin
                    w_nextState = w_startFullErr ? ST_DONE : ST_SEND_STR;
                end else if (i_start_pat) begin
                    w_nextState = w_startPatErr ? ST_DONE : ST_SEND_PAT;
                end
            end
            ST_SEND_STR: if (w_strLast) w_nextState = ST_GAP;
            ST_GAP:      w_nextState = ST_SEND_PAT;
            ST_SEND_PAT: if (w_patLast) w_nextState = ST_WAIT;
            ST_WAIT:     if (i_valid || w_waitExpired) w_nextState = ST_DONE;
            ST_DONE:     w_nextState = ST_IDLE;
            default:     w_nextState = ST_IDLE;
        endcase
    end

    // Output decode. Outputs depend only on state so an async reset drops
    // the qualifiers immediately.
    always_comb begin
        o_chardata  = 8'h00;
        o_isstring  = 1'b0;
        o_ispattern = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_SEND_STR: begin
                o_isstring = 1'b1;
                o_chardata = w_strData;
            end
            ST_SEND_PAT: begin
                o_ispattern = 1'b1;
                o_chardata  = w_patData;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: send index, wait timer, string-sent flag and result capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx      <= '0;
            r_waitCnt  <= '0;
            r_strSent  <= 1'b0;
            r_resMatch <= 1'b0;
            r_resIndex <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == ST_SEND_STR || r_state == ST_SEND_PAT) && r_state == w_nextState) begin
                r_idx <= w_idxNext;
            end else begin
                r_idx <= '0;
            end

            r_waitCnt <= (r_state == ST_WAIT) ? r_waitCnt + WCNT_W'(1) : '0;

            if (w_idle && i_start_full && !w_startFullErr) begin
                r_strSent <= 1'b1;
            end else if (w_bufWrEn && i_str_clr) begin
                r_strSent <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_nextState == ST_DONE) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_valid) begin
                        r_resMatch <= i_match;
                        r_resIndex <= i_match_index;
                        r_err      <= 1'b0;
                    end else if (w_waitExpired) begin
                        r_resMatch <= 1'b0;
                        r_err      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_res_match = r_resMatch;
    assign o_res_index = r_resIndex;
    assign o_err       = r_err;

endmodule

// File: tb/tb_sme_host_driver.sv
// ---------------------------------------------------------------------------
// tb_sme_host_driver
// Directed testbench for sme_host_driver. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the
// rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_sme_host_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       str_wr, str_clr, pat_wr, pat_clr;
    logic [7:0] str_wdata, pat_wdata;
    logic       start_full, start_pat;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;
    logic       busy, done, res_match, err;
    logic [4:0] res_index;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sme_host_driver #(.STR_MAX(32), .PAT_MAX(8), .WAIT_MAX(64)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_str_wr      (str_wr),
        .i_str_wdata   (str_wdata),
        .i_str_clr     (str_clr),
        .i_pat_wr      (pat_wr),
        .i_pat_wdata   (pat_wdata),
        .i_pat_clr     (pat_clr),
        .i_start_full  (start_full),
        .i_start_pat   (start_pat),
        .o_chardata    (chardata),
        .o_isstring    (isstring),
        .o_ispattern   (ispattern),
        .i_valid       (valid),
        .i_match       (match),
        .i_match_index (match_index),
        .o_busy        (busy),
        .o_done        (done),
        .o_res_match   (res_match),
        .o_res_index   (res_index),
        .o_err         (err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic writeStr(input logic [7:0] c);
        str_wr = 1'b1; str_wdata = c; step(); str_wr = 1'b0;
    endtask

    task automatic writePat(input logic [7:0] c);
        pat_wr = 1'b1; pat_wdata = c; step(); pat_wr = 1'b0;
    endtask

    // Holds valid until the run completes, then steps back into idle.
    task automatic drainRun(output bit ok);
        ok = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (chardata !== 8'h00) begin errors++; $display("FAIL reset_chardata: got %h expected 00", chardata); end
        checks++; if (isstring !== 1'b0) begin errors++; $display("FAIL reset_isstring: got %b expected 0", isstring); end
        checks++; if (ispattern !== 1'b0) begin errors++; $display("FAIL reset_ispattern: got %b expected 0", ispattern); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (res_match !== 1'b0) begin errors++; $display("FAIL reset_res_match: got %b expected 0", res_match); end
        checks++; if (res_index !== 5'd0) begin errors++; $display("FAIL reset_res_index: got %0d expected 0", res_index); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_start_errors();
        // start_pat with nothing sent since reset
        start_pat = 1'b1; step(); start_pat = 1'b0;
        checks++; if ({done, err} !== 2'b11) begin errors++; $display("FAIL pat_after_reset_done_err: got %b expected 11", {done, err}); end
        checks++; if ({isstring, ispattern} !== 2'b00) begin errors++; $display("FAIL pat_after_reset_quals: got %b expected 00", {isstring, ispattern}); end
        step();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL pat_after_reset_idle: got %b expected 00", {done, busy}); end
        // start_full with empty buffers
        start_full = 1'b1; step(); start_full = 1'b0;
        checks++; if ({done, err, isstring} !== 3'b110) begin errors++; $display("FAIL full_empty: got %b expected 110", {done, err, isstring}); end
        step();
    endtask

    task automatic test_full_run();
        logic [7:0] s [3];
        logic [7:0] p [2];
        s = '{8'h61, 8'h62, 8'h63};
        p = '{8'h62, 8'h63};
        for (int i = 0; i < 3; i++) writeStr(s[i]);
        for (int i = 0; i < 2; i++) writePat(p[i]);
        start_full = 1'b1; step(); start_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({isstring, ispattern, chardata} !== {2'b10, s[k]}) begin errors++; $display("FAIL full_str%0d: got %b/%h expected 10/%h", k, {isstring, ispattern}, chardata, s[k]); end
            step();
        end
        checks++; if ({isstring, ispattern, chardata, busy} !== {2'b00, 8'h00, 1'b1}) begin errors++; $display("FAIL full_gap: got %b/%h/%b expected 00/00/1", {isstring, ispattern}, chardata, busy); end
        step();
        for (int j = 0; j < 2; j++) begin
            checks++; if ({isstring, ispattern, chardata} !== {2'b01, p[j]}) begin errors++; $display("FAIL full_pat%0d: got %b/%h expected 01/%h", j, {isstring, ispattern}, chardata, p[j]); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) start_pat = 1'b1;
            checks++; if ({isstring, ispattern, busy, done} !== 4'b0010) begin errors++; $display("FAIL full_wait%0d: got %b expected 0010", i, {isstring, ispattern, busy, done}); end
            step();
            start_pat = 1'b0;
        end
        valid = 1'b1; match = 1'b1; match_index = 5'd1;
        step();
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        checks++; if ({done, res_match, res_index, err} !== {1'b1, 1'b1, 5'd1, 1'b0}) begin errors++; $display("FAIL full_done: got done=%b m=%b idx=%0d err=%b expected 1 1 1 0", done, res_match, res_index, err); end
        step();
        checks++; if ({done, busy, res_match, res_index} !== {1'b0, 1'b0, 1'b1, 5'd1}) begin errors++; $display("FAIL full_after: got done=%b busy=%b m=%b idx=%0d expected 0 0 1 1", done, busy, res_match, res_index); end
    endtask

    task automatic test_start_pat();
        logic [7:0] p [2];
        p = '{8'h5E, 8'h78};
        pat_clr = 1'b1; step(); pat_clr = 1'b0;
        for (int i = 0; i < 2; i++) writePat(p[i]);
        start_pat = 1'b1; step(); start_pat = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++; if ({isstring, ispattern, chardata} !== {2'b01, p[j]}) begin errors++; $display("FAIL patonly_pat%0d: got %b/%h expected 01/%h", j, {isstring, ispattern}, chardata, p[j]); end
            step();
        end
        valid = 1'b1; match = 1'b0; match_index = 5'd7;
        step();
        valid = 1'b0; match_index = 5'd0;
        checks++; if ({done, res_match, res_index, err} !== {1'b1, 1'b0, 5'd7, 1'b0}) begin errors++; $display("FAIL patonly_done: got done=%b m=%b idx=%0d err=%b expected 1 0 7 0", done, res_match, res_index, err); end
        step();
    endtask

    task automatic test_timeout();
        bit anyDone = 1'b0;
        bit notBusy = 1'b0;
        start_pat = 1'b1; step(); start_pat = 1'b0;
        checks++; if ({ispattern, chardata} !== {1'b1, 8'h5E}) begin errors++; $display("FAIL rerun_pat0: got %b/%h expected 1/5e", ispattern, chardata); end
        valid = 1'b1; match = 1'b1; match_index = 5'd3;
        step();
        checks++; if ({ispattern, chardata} !== {1'b1, 8'h78}) begin errors++; $display("FAIL rerun_pat1: got %b/%h expected 1/78", ispattern, chardata); end
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        step();
        for (int i = 0; i < 64; i++) begin
            if (done) anyDone = 1'b1;
            if (!busy) notBusy = 1'b1;
            step();
        end
        checks++; if ({anyDone, notBusy} !== 2'b00) begin errors++; $display("FAIL timeout_wait: got done_seen/idle_seen=%b expected 00", {anyDone, notBusy}); end
        checks++; if ({done, err, res_match, res_index} !== {1'b1, 1'b1, 1'b0, 5'd7}) begin errors++; $display("FAIL timeout_done: got done=%b err=%b m=%b idx=%0d expected 1 1 0 7", done, err, res_match, res_index); end
        step();
    endtask

    task automatic test_clr_wins();
        pat_clr = 1'b1; pat_wr = 1'b1; pat_wdata = 8'h41;
        step();
        pat_clr = 1'b0; pat_wr = 1'b0;
        start_pat = 1'b1; step(); start_pat = 1'b0;
        checks++; if ({done, err, ispattern} !== 3'b110) begin errors++; $display("FAIL clr_wins: got %b expected 110", {done, err, ispattern}); end
        step();
        writePat(8'h5E);
        writePat(8'h78);
    endtask

    task automatic test_overflow();
        int  cnt = 0;
        bit  charOk = 1'b1;
        bit  ok;
        str_clr = 1'b1; step(); str_clr = 1'b0;
        for (int i = 0; i < 33; i++) writeStr(8'h20 + 8'(i));
        start_full = 1'b1; start_pat = 1'b1;
        step();
        start_full = 1'b0; start_pat = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!isstring) break;
            if (chardata !== 8'h20 + 8'(cnt)) charOk = 1'b0;
            cnt++;
            step();
        end
        checks++; if (cnt !== 32) begin errors++; $display("FAIL overflow_len: got %0d string cycles expected 32", cnt); end
        checks++; if (charOk !== 1'b1) begin errors++; $display("FAIL overflow_chars: got ok=%b expected 1", charOk); end
        drainRun(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL overflow_done: got %b expected 1", ok); end
    endtask

    task automatic test_mid_reset();
        bit anyDone = 1'b0;
        start_full = 1'b1; step(); start_full = 1'b0;
        step();
        checks++; if (isstring !== 1'b1) begin errors++; $display("FAIL midreset_pre: got %b expected 1", isstring); end
        reset = 1'b1;
        #1;
        checks++; if ({isstring, ispattern, busy} !== 3'b000) begin errors++; $display("FAIL midreset_abort: got %b expected 000", {isstring, ispattern, busy}); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) anyDone = 1'b1;
            step();
        end
        checks++; if (anyDone !== 1'b0) begin errors++; $display("FAIL midreset_nodone: got %b expected 0", anyDone); end
        start_pat = 1'b1; step(); start_pat = 1'b0;
        checks++; if ({done, err, ispattern} !== 3'b110) begin errors++; $display("FAIL midreset_pat: got %b expected 110", {done, err, ispattern}); end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        str_wr = 1'b0; str_clr = 1'b0; pat_wr = 1'b0; pat_clr = 1'b0;
        str_wdata = 8'h00; pat_wdata = 8'h00;
        start_full = 1'b0; start_pat = 1'b0;
        valid = 1'b0; match = 1'b0; match_index = 5'd0;
        test_reset();
        test_start_errors();
        test_full_run();
        test_start_pat();
        test_timeout();
        test_clr_wins();
        test_overflow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sme_host_driver.md
SME_HOST_DRIVER -- requirements
Module: sme_host_driver

Interface
REQ-001 Parameter STR_MAX, default 32, maximum string length in characters.
REQ-002 Parameter PAT_MAX, default 8, maximum pattern length in characters.
REQ-003 Parameter WAIT_MAX, default 64, cycles allowed for valid after last pattern character.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 str_wr  input  1  append str_wdata to string buffer.
REQ-007 pat_wr  input  1  append pat_wdata to pattern buffer.
REQ-008 str_wdata / pat_wdata  input  8 each  character bytes.
REQ-009 str_clr / pat_clr  input  1 each  empty the respective buffer.
REQ-010 start_full  input  1  send string then pattern.
REQ-011 start_pat  input  1  send pattern only, reusing the last string sent.
REQ-012 chardata  output  8  character to matcher.
REQ-013 isstring / ispattern  output  1 each  qualifiers for chardata.
REQ-014 valid  input  1  matcher result strobe.
REQ-015 match  input  1  matcher hit flag, qualified by valid.
REQ-016 match_index  input  5  matcher hit position, qualified by valid.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 res_match / res_index  output  1 / 5  captured result, held until next done.
REQ-020 err  output  1  error code of last run; held until next done.

Function
REQ-021 States SHALL be IDLE, SEND_STR, GAP, SEND_PAT, WAIT, DONE.
REQ-022 Writes SHALL be accepted only in IDLE; writes while busy SHALL be dropped.
REQ-023 A write to a full buffer SHALL be dropped; the length counter saturates at STR_MAX or PAT_MAX.
REQ-024 When clr and wr are asserted in the same cycle, clr SHALL win and the buffer SHALL be empty afterwards.
REQ-025 start_full accepted in IDLE at cycle t with string length N >= 1 and pattern length M >= 1:
- isstring=1 with character k in cycles t+1+k, k = 0..N-1;
- cycle t+N+1: GAP, both qualifiers low;
- ispattern=1 with pattern character j in cycles t+N+2+j, j = 0..M-1;
- then WAIT.
REQ-026 start_pat accepted at t SHALL skip SEND_STR and GAP and drive pattern character j in cycle t+1+j.
REQ-027 isstring and ispattern SHALL never be high together; chardata SHALL be 0 whenever both are low.
REQ-028 In WAIT, the first cycle with valid=1 SHALL capture match and match_index into res_match and res_index, set err=0, and enter DONE.
REQ-029 If WAIT_MAX WAIT cycles elapse without valid, the block SHALL set err=1 and res_match=0, keep res_index, and enter DONE.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 The following SHALL produce a one-cycle err=1 done pulse at t+1 with no characters sent:
- start_full with N=0 or M=0;
- start_pat with M=0;
- start_pat when no string has been sent since reset or since str_clr.
REQ-032 If start_full and start_pat are asserted together, start_full SHALL win.
REQ-033 start signals while busy SHALL be ignored.
REQ-034 valid outside WAIT SHALL be ignored.
REQ-035 Buffers SHALL be retained after a run, so repeated start_pat reruns the same pattern.

Reset
REQ-036 Reset SHALL force IDLE and clear buffer lengths and the string-sent flag.
REQ-037 At reset, the outputs chardata, isstring, ispattern, busy, done, res_match, res_index and err SHALL all be 0.
REQ-038 Reset during SEND_* or WAIT SHALL abort immediately: qualifiers fall in the same cycle and no done pulse is issued.

Structure
REQ-039 A shared package SHALL hold:
- the state encoding;
- the STR_MAX, PAT_MAX and WAIT_MAX defaults;
- the character constants: ^ 8'h5E, $ 8'h24, . 8'h2E, * 8'h2A.
REQ-040 One sub-module, sme_char_buf, parameterized by depth, SHALL implement each buffer with write pointer, length, clear and read index; it is instantiated twice.

Verification
REQ-041 String "abc" (N=3), pattern "bc", start_full at t=10, valid=1 match=1 index=1 at t=20: isstring at t=11..13, GAP at t=14, ispattern at t=15..16, done at t=21 with res_match=1, res_index=1, err=0.
REQ-042 start_pat after REQ-041 with a new pattern "^x": ispattern at t+1..t+2, no isstring, valid with match=0 -> res_match=0, err=0.
REQ-043 No valid for 64 WAIT cycles -> done on the next cycle with err=1 and res_match=0.
REQ-044 33 string writes -> length 32; start_full drives exactly 32 isstring cycles.
REQ-045 start_pat immediately after reset -> done at t+1 with err=1 and qualifiers never high.
REQ-046 Reset asserted mid-SEND_STR -> qualifiers low that cycle, busy=0, no done pulse, and start_pat then reports err=1.
